// File: rtl/conv1d_cfu.sv
// conv1d_cfu: CFU-attached int8 1-D "same" convolution engine, one MAC per cycle
module conv1d_cfu #(
    parameter int KERNEL_LEN = 8,
    parameter int MAX_LEN    = 1024,
    parameter int ACC_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int KW = $clog2(KERNEL_LEN);
    localparam int JW = AW + 8;

    typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;
    state_t state, state_next;

    logic [7:0]        x_mem [MAX_LEN];
    logic [7:0]        w_mem [KERNEL_LEN];
    logic [ACC_W-1:0]  y_mem [MAX_LEN];
    logic [LW-1:0]     len;
    logic signed [8:0] offset;
    logic [AW-1:0]     i;
    logic [KW-1:0]     k;
    logic [ACC_W-1:0]  acc;
    logic [6:0]        funct;
    logic              accept, busy, cfg, start, last_tap, last_out, in_range;
    logic [JW-1:0]     j;
    logic [7:0]        x_tap;
    logic signed [9:0] p;
    logic signed [17:0] prod;
    logic [31:0]       rsp_data;
    logic              unused;

    assign funct     = cmd_payload_function_id[9:3];
    assign unused    = ^cmd_payload_function_id[2:0];
    assign cmd_ready = ~rsp_valid;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = state != IDLE;
    assign cfg       = accept && !busy;
    assign start     = cfg && funct == 7'd5 && len != '0;
    assign last_tap  = k == KW'(KERNEL_LEN - 1);
    assign last_out  = LW'(i) == len - LW'(1);

    // Input position of the current tap; negative or >= len means zero padding.
    assign j        = JW'(i) + JW'(k) - JW'(KERNEL_LEN / 2);
    assign in_range = !j[JW-1] && j < JW'(len);
    assign x_tap    = x_mem[j[AW-1:0]];
    assign p        = in_range ? {{2{x_tap[7]}}, x_tap} + {offset[8], offset} : '0;
    assign prod     = p * $signed(w_mem[k]);

    assign rsp_data = (busy && funct != 7'd7) ? '1 :
                      (funct == 7'd7) ? {31'b0, busy} :
                      (funct == 7'd6 && cmd_payload_inputs_0 < MAX_LEN) ? y_mem[cmd_payload_inputs_0[AW-1:0]] : '0;

    // Next-state logic: each output takes KERNEL_LEN MAC cycles plus one WRITE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? MAC : IDLE;
            MAC:     state_next = last_tap ? WRITE : MAC;
            WRITE:   state_next = last_out ? IDLE : MAC;
            default: state_next = IDLE;
        endcase
    end

    // Control registers, response channel and MAC datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            rsp_valid             <= 1'b0;
            rsp_payload_outputs_0 <= '0;
            len                   <= '0;
            offset                <= '0;
            i                     <= '0;
            k                     <= '0;
            acc                   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rsp_valid             <= 1'b1;
                rsp_payload_outputs_0 <= rsp_data;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (cfg && funct == 7'd0) begin
                len    <= '0;
                offset <= '0;
            end
            if (cfg && funct == 7'd3)
                len <= (cmd_payload_inputs_0 > MAX_LEN) ? LW'(MAX_LEN) : cmd_payload_inputs_0[LW-1:0];
            if (cfg && funct == 7'd4)
                offset <= $signed(cmd_payload_inputs_0[8:0]);
            if (start) begin
                i   <= '0;
                k   <= '0;
                acc <= '0;
            end else if (state == MAC) begin
                acc <= acc + {{(ACC_W-18){prod[17]}}, prod};
                k   <= last_tap ? '0 : k + 1'b1;
            end else if (state == WRITE) begin
                acc <= '0;
                i   <= i + 1'b1;
            end
        end
    end

    // Vector storage: byte writes from the CPU, result writes from the WRITE state.
    always_ff @(posedge clk) begin
        if (!reset && cfg) begin
            for (int b = 0; b < 4; b++) begin
                if (funct == 7'd1 && {cmd_payload_inputs_0, 2'(b)} < 34'(MAX_LEN))
                    x_mem[AW'({cmd_payload_inputs_0, 2'(b)})] <= cmd_payload_inputs_1[8*b +: 8];
                if (funct == 7'd2 && {cmd_payload_inputs_0, 2'(b)} < 34'(KERNEL_LEN))
                    w_mem[KW'({cmd_payload_inputs_0, 2'(b)})] <= cmd_payload_inputs_1[8*b +: 8];
            end
        end
        if (!reset && state == WRITE)
            y_mem[i] <= acc;
    end
endmodule
